// File: rtl/cve2_fetch_req_engine.sv
// Instruction-side bus request engine: issues word-aligned fetch requests, tracks
// outstanding responses and drops those belonging to a stream abandoned by a branch.
module cve2_fetch_req_engine #(
    parameter int NUM_REQS = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    input  logic                branch_i,
    input  logic [31:0]         addr_i,
    output logic                busy_o,
    input  logic [NUM_REQS-1:0] fifo_busy_i,
    output logic                fifo_clear_o,
    output logic [31:0]         fifo_addr_o,
    output logic                fifo_valid_o,
    output logic [31:0]         fifo_rdata_o,
    output logic                fifo_err_o,
    output logic                instr_req_o,
    input  logic                instr_gnt_i,
    output logic [31:0]         instr_addr_o,
    input  logic                instr_rvalid_i,
    input  logic [31:0]         instr_rdata_i,
    input  logic                instr_err_i
);

    localparam int CW = $clog2(NUM_REQS + 1);
    localparam int SW = $clog2(2 * NUM_REQS + 1);

    typedef enum logic {
        IDLE,
        WAIT_GNT
    } state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [31:2]         r_fetch_addr;
    logic [31:2]         r_stored_addr;
    logic [31:2]         r_redir_addr;
    logic                r_redirect;
    logic [CW-1:0]       r_out_cnt;
    logic [NUM_REQS-1:0] r_disc;

    logic [31:2]         w_fetch_next;
    logic [31:2]         w_stored_next;
    logic [31:2]         w_redir_addr_next;
    logic                w_redirect_next;
    logic [CW-1:0]       w_out_cnt_next;
    logic [NUM_REQS-1:0] w_disc_next;
    logic [SW-1:0]       w_busy_cnt;
    logic                w_can_issue;
    logic                w_slot_free;
    logic                w_new_req;
    logic                w_req;
    logic                w_grant;
    logic                w_new_disc;
    logic [31:2]         w_addr_word;
    logic [31:2]         w_target;
    logic [CW-1:0]       w_append_idx;

    assign w_target = addr_i[31:2];

    // FIFO upper entries that are occupied also consume fetch slots.
    always_comb begin
        w_busy_cnt = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            w_busy_cnt = w_busy_cnt + SW'(fifo_busy_i[i]);
        end
    end

    assign w_can_issue = (SW'(r_out_cnt) + w_busy_cnt) < SW'(NUM_REQS);
    assign w_slot_free = r_out_cnt < CW'(NUM_REQS);
    assign w_new_req   = req_i & (w_can_issue | branch_i) & w_slot_free;
    assign w_grant     = w_req & instr_gnt_i;

    always_comb begin
        w_state_next      = r_state;
        w_req             = 1'b0;
        w_addr_word       = r_fetch_addr;
        w_new_disc        = 1'b0;
        w_fetch_next      = r_fetch_addr;
        w_stored_next     = r_stored_addr;
        w_redirect_next   = r_redirect;
        w_redir_addr_next = r_redir_addr;
        case (r_state)
            IDLE: begin
                w_req       = w_new_req;
                w_addr_word = branch_i ? w_target : r_fetch_addr;
                if (branch_i) begin
                    w_fetch_next = w_target;
                end
                if (w_new_req && instr_gnt_i) begin
                    w_fetch_next = w_addr_word + 30'd1;
                end else if (w_new_req) begin
                    w_state_next  = WAIT_GNT;
                    w_stored_next = w_addr_word;
                end
            end
            WAIT_GNT: begin
                // The bus address must hold until grant, so a branch is only recorded here.
                w_req       = 1'b1;
                w_addr_word = r_stored_addr;
                if (branch_i) begin
                    w_redirect_next   = 1'b1;
                    w_redir_addr_next = w_target;
                end
                if (instr_gnt_i) begin
                    w_state_next    = IDLE;
                    w_new_disc      = branch_i | r_redirect;
                    w_redirect_next = 1'b0;
                    if (branch_i) begin
                        w_fetch_next = w_target;
                    end else if (r_redirect) begin
                        w_fetch_next = r_redir_addr;
                    end else begin
                        w_fetch_next = r_stored_addr + 30'd1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Discard bits: mark on branch, retire oldest on response, append newest on grant.
    always_comb begin
        w_disc_next = r_disc;
        if (branch_i) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (CW'(i) < r_out_cnt) begin
                    w_disc_next[i] = 1'b1;
                end
            end
        end
        if (instr_rvalid_i) begin
            w_disc_next = w_disc_next >> 1;
        end
        w_append_idx = r_out_cnt - CW'(instr_rvalid_i);
        if (w_grant) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (CW'(i) == w_append_idx) begin
                    w_disc_next[i] = w_new_disc;
                end
            end
        end
    end

    assign w_out_cnt_next = r_out_cnt + CW'(w_grant) - CW'(instr_rvalid_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= IDLE;
            r_fetch_addr  <= '0;
            r_stored_addr <= '0;
            r_redir_addr  <= '0;
            r_redirect    <= 1'b0;
            r_out_cnt     <= '0;
            r_disc        <= '0;
        end else begin
            r_state       <= w_state_next;
            r_fetch_addr  <= w_fetch_next;
            r_stored_addr <= w_stored_next;
            r_redir_addr  <= w_redir_addr_next;
            r_redirect    <= w_redirect_next;
            r_out_cnt     <= w_out_cnt_next;
            r_disc        <= w_disc_next;
        end
    end

    assign instr_req_o  = w_req;
    assign instr_addr_o = {w_addr_word, 2'b00};
    assign busy_o       = (r_state == WAIT_GNT) | (r_out_cnt != '0);
    assign fifo_clear_o = branch_i;
    assign fifo_addr_o  = addr_i;
    assign fifo_valid_o = instr_rvalid_i & ~r_disc[0] & ~branch_i;
    assign fifo_rdata_o = instr_rdata_i;
    assign fifo_err_o   = instr_err_i;

    assert property (@(posedge clk_i) disable iff (!rst_ni) instr_rvalid_i |-> (r_out_cnt != '0));

endmodule

// File: tb/tb_cve2_fetch_req_engine.sv
// Directed bench for cve2_fetch_req_engine: stimulus queues expected grants and FIFO
// pushes, a negedge monitor pops and compares whenever the DUT presents one.
module tb_cve2_fetch_req_engine;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_i;
    logic        branch_i;
    logic [31:0] addr_i;
    logic        busy_o;
    logic [1:0]  fifo_busy_i;
    logic        fifo_clear_o;
    logic [31:0] fifo_addr_o;
    logic        fifo_valid_o;
    logic [31:0] fifo_rdata_o;
    logic        fifo_err_o;
    logic        instr_req_o;
    logic        instr_gnt_i;
    logic [31:0] instr_addr_o;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_err_i;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [31:0] gntQ[$];
    logic [32:0] pushQ[$];

    cve2_fetch_req_engine #(.NUM_REQS(2)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_i          (req_i),
        .branch_i       (branch_i),
        .addr_i         (addr_i),
        .busy_o         (busy_o),
        .fifo_busy_i    (fifo_busy_i),
        .fifo_clear_o   (fifo_clear_o),
        .fifo_addr_o    (fifo_addr_o),
        .fifo_valid_o   (fifo_valid_o),
        .fifo_rdata_o   (fifo_rdata_o),
        .fifo_err_o     (fifo_err_o),
        .instr_req_o    (instr_req_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_addr_o   (instr_addr_o),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .instr_err_i    (instr_err_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs shortly after the rising edge.
    task automatic applyStimulus(input logic req, input logic gnt, input logic rv,
                                 input logic [31:0] rdata, input logic err,
                                 input logic br, input logic [31:0] baddr,
                                 input logic [1:0] busy);
        @(posedge clk_i);
        #1;
        req_i          = req;
        instr_gnt_i    = gnt;
        instr_rvalid_i = rv;
        instr_rdata_i  = rdata;
        instr_err_i    = err;
        branch_i       = br;
        addr_i         = baddr;
        fifo_busy_i    = busy;
    endtask

    task automatic settle();
        #2;
    endtask

    // Monitor: compares every granted request and every FIFO push against the queues.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_ni) begin
                if (instr_req_o && instr_gnt_i) begin
                    if (gntQ.size() == 0) begin
                        checkOutput("grantUnexpected", {32'h0, instr_addr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        checkOutput("grantAddr", {32'h0, instr_addr_o}, {32'h0, gntQ.pop_front()});
                    end
                end
                if (fifo_valid_o) begin
                    if (pushQ.size() == 0) begin
                        checkOutput("pushUnexpected", {31'h0, fifo_err_o, fifo_rdata_o}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        checkOutput("pushData", {31'h0, fifo_err_o, fifo_rdata_o}, {31'h0, pushQ.pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        rst_ni = 1'b0;
        req_i = 1'b0; branch_i = 1'b0; addr_i = '0; fifo_busy_i = '0;
        instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0; instr_err_i = 1'b0;
        #22;
        checkOutput("resetReq", {63'h0, instr_req_o}, 64'h0);
        checkOutput("resetValid", {63'h0, fifo_valid_o}, 64'h0);
        checkOutput("resetBusy", {63'h0, busy_o}, 64'h0);
        checkOutput("resetAddr", {32'h0, instr_addr_o}, 64'h0);
        #4;
        rst_ni = 1'b1;

        // Sequential fetch: grant every cycle, response one cycle later
        applyStimulus(1, 1, 0, 32'h0, 0, 0, 32'h0, 2'b00); gntQ.push_back(32'h0);
        applyStimulus(1, 1, 1, 32'hD000_0000, 0, 0, 32'h0, 2'b00); gntQ.push_back(32'h4); pushQ.push_back({1'b0, 32'hD000_0000});
        applyStimulus(1, 1, 1, 32'hD000_0004, 0, 0, 32'h0, 2'b00); gntQ.push_back(32'h8); pushQ.push_back({1'b0, 32'hD000_0004});
        applyStimulus(1, 1, 1, 32'hD000_0008, 0, 0, 32'h0, 2'b00); gntQ.push_back(32'hC); pushQ.push_back({1'b0, 32'hD000_0008});
        applyStimulus(0, 0, 1, 32'hD000_000C, 0, 0, 32'h0, 2'b00); pushQ.push_back({1'b0, 32'hD000_000C});
        settle(); checkOutput("seqNoReq", {63'h0, instr_req_o}, 64'h0);
        applyStimulus(0, 0, 0, 32'h0, 0, 0, 32'h0, 2'b00);
        settle(); checkOutput("seqIdleBusy", {63'h0, busy_o}, 64'h0);

        // Grant stall with a branch during the stall
        applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0, 2'b00);
        settle(); checkOutput("stallReq", {63'h0, instr_req_o}, 64'h1);
        checkOutput("stallAddr0", {32'h0, instr_addr_o}, 64'h10);
        applyStimulus(1, 0, 0, 32'h0, 0, 1, 32'h100, 2'b00);
        settle(); checkOutput("stallAddr1", {32'h0, instr_addr_o}, 64'h10);
        checkOutput("stallClear", {63'h0, fifo_clear_o}, 64'h1);
        applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0, 2'b00);
        settle(); checkOutput("stallAddr2", {32'h0, instr_addr_o}, 64'h10);
        checkOutput("stallBusy", {63'h0, busy_o}, 64'h1);
        applyStimulus(1, 1, 0, 32'h0, 0, 0, 32'h0, 2'b00); gntQ.push_back(32'h10);
        applyStimulus(1, 1, 1, 32'hDEAD_0010, 0, 0, 32'h0, 2'b00); gntQ.push_back(32'h100);
        settle(); checkOutput("stallDropped", {63'h0, fifo_valid_o}, 64'h0);
        applyStimulus(1, 1, 1, 32'hD000_0100, 0, 0, 32'h0, 2'b00); gntQ.push_back(32'h104); pushQ.push_back({1'b0, 32'hD000_0100});
        applyStimulus(1, 1, 0, 32'h0, 0, 0, 32'h0, 2'b00); gntQ.push_back(32'h108);

        // Branch with two responses outstanding
        applyStimulus(1, 0, 0, 32'h0, 0, 1, 32'h202, 2'b00);
        settle(); checkOutput("brClear", {63'h0, fifo_clear_o}, 64'h1);
        checkOutput("brFifoAddr", {32'h0, fifo_addr_o}, 64'h202);
        checkOutput("brFullNoReq", {63'h0, instr_req_o}, 64'h0);
        applyStimulus(1, 1, 1, 32'hDEAD_0104, 0, 0, 32'h0, 2'b00);
        settle(); checkOutput("brDrop0", {63'h0, fifo_valid_o}, 64'h0);
        applyStimulus(1, 1, 1, 32'hDEAD_0108, 0, 0, 32'h0, 2'b00); gntQ.push_back(32'h200);
        settle(); checkOutput("brDrop1", {63'h0, fifo_valid_o}, 64'h0);
        applyStimulus(1, 1, 1, 32'hD000_0200, 0, 0, 32'h0, 2'b00); gntQ.push_back(32'h204); pushQ.push_back({1'b0, 32'hD000_0200});
        applyStimulus(0, 0, 1, 32'hD000_0204, 0, 0, 32'h0, 2'b00); pushQ.push_back({1'b0, 32'hD000_0204});

        // FIFO backpressure
        applyStimulus(1, 1, 0, 32'h0, 0, 0, 32'h0, 2'b11);
        settle(); checkOutput("bpNoReq0", {63'h0, instr_req_o}, 64'h0);
        applyStimulus(1, 1, 0, 32'h0, 0, 0, 32'h0, 2'b11);
        settle(); checkOutput("bpNoReq1", {63'h0, instr_req_o}, 64'h0);
        applyStimulus(1, 1, 0, 32'h0, 0, 0, 32'h0, 2'b01); gntQ.push_back(32'h208);
        settle(); checkOutput("bpReqResume", {63'h0, instr_req_o}, 64'h1);
        applyStimulus(1, 1, 1, 32'hD000_0208, 0, 0, 32'h0, 2'b01); pushQ.push_back({1'b0, 32'hD000_0208});
        settle(); checkOutput("bpNoReq2", {63'h0, instr_req_o}, 64'h0);
        applyStimulus(0, 0, 0, 32'h0, 0, 0, 32'h0, 2'b00);

        // Response in the same cycle as a branch
        applyStimulus(1, 1, 0, 32'h0, 0, 0, 32'h0, 2'b00); gntQ.push_back(32'h20C);
        applyStimulus(1, 1, 1, 32'hDEAD_020C, 0, 1, 32'h300, 2'b00); gntQ.push_back(32'h300);
        settle(); checkOutput("simulValid", {63'h0, fifo_valid_o}, 64'h0);
        checkOutput("simulAddr", {32'h0, instr_addr_o}, 64'h300);
        applyStimulus(0, 0, 1, 32'hD000_0300, 0, 0, 32'h0, 2'b00); pushQ.push_back({1'b0, 32'hD000_0300});

        // Error response, fetch continues at the next word
        applyStimulus(1, 1, 0, 32'h0, 0, 0, 32'h0, 2'b00); gntQ.push_back(32'h304);
        applyStimulus(1, 1, 1, 32'hD000_0304, 1, 0, 32'h0, 2'b00); gntQ.push_back(32'h308); pushQ.push_back({1'b1, 32'hD000_0304});
        settle(); checkOutput("errFlag", {63'h0, fifo_err_o}, 64'h1);
        checkOutput("errValid", {63'h0, fifo_valid_o}, 64'h1);
        applyStimulus(0, 0, 1, 32'hD000_0308, 0, 0, 32'h0, 2'b00); pushQ.push_back({1'b0, 32'hD000_0308});
        applyStimulus(0, 0, 0, 32'h0, 0, 0, 32'h0, 2'b00);
        settle(); checkOutput("endBusy", {63'h0, busy_o}, 64'h0);

        #10;
        checkOutput("gntQueueEmpty", 64'(gntQ.size()), 64'h0);
        checkOutput("pushQueueEmpty", 64'(pushQ.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
